gpio_reset_conditioner: RTL and testbench



---
 rtl/gpio_reset_conditioner.sv | 152 +++++++++++++++
 tb/tb_gpio_reset_conditioner.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_reset_conditioner.sv
// GPIO front-end: synchronises and debounces the board pins, then turns the
// bit-0 reset button plus a power-on window into a registered SoC reset.
module gpio_reset_conditioner #(
  parameter int                GPIO_W          = 4,
  parameter int                SYNC_STAGES     = 2,
  parameter int                DEBOUNCE_CYCLES = 64,
  parameter logic              PRESS_LEVEL     = 1'b0,
  parameter logic [GPIO_W-1:0] GPIO_IDLE       = GPIO_W'(4'b0001),
  parameter int                POR_CYCLES      = 32,
  parameter int                RST_STRETCH     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_db,
  output logic              soc_reset,
  output logic              press_pulse,
  output logic [7:0]        press_count,
  output logic [1:0]        state_dbg
);

  localparam int DW   = $clog2(DEBOUNCE_CYCLES);
  localparam int CMAX = (POR_CYCLES > RST_STRETCH) ? POR_CYCLES : RST_STRETCH;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] POR_LOAD = CW'(POR_CYCLES - 1);
  localparam logic [CW-1:0] STR_LOAD = CW'(RST_STRETCH - 1);

  typedef enum logic [1:0] {
    ST_POR     = 2'd0,
    ST_RUN     = 2'd1,
    ST_HELD    = 2'd2,
    ST_STRETCH = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q;
  logic [GPIO_W-1:0]                  sync;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{GPIO_IDLE}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Each bit owns its own stability counter; any agreement restarts it.
  for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_db
    logic [DW-1:0] cnt_q, cnt_d;
    logic          db_q, db_d;

    always_comb begin
      cnt_d = '0;
      db_d  = db_q;
      if (sync[gi] != db_q) begin
        if (cnt_q == DB_LAST) begin
          db_d = sync[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q <= '0;
        db_q  <= GPIO_IDLE[gi];
      end else begin
        cnt_q <= cnt_d;
        db_q  <= db_d;
      end
    end

    assign gpio_db[gi] = db_q;
  end

  state_t        state_q, state_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          pulse_q, pulse_d;
  logic [7:0]    count_q, count_d;
  logic          soc_q;
  logic          pressed;

  assign pressed = (gpio_db[0] == PRESS_LEVEL);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    pulse_d = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_POR: begin
        // A press already debounced here is taken as held, not as a new press.
        if (fcnt_q == '0) begin
          state_d = pressed ? ST_HELD : ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      ST_RUN: begin
        if (pressed) begin
          state_d = ST_HELD;
          pulse_d = 1'b1;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end
      end
      ST_HELD: begin
        if (!pressed) begin
          state_d = ST_STRETCH;
          fcnt_d  = STR_LOAD;
        end
      end
      ST_STRETCH: begin
        if (pressed) begin
          state_d = ST_HELD;
          pulse_d = 1'b1;
          if (count_q != 8'hFF) count_d = count_q + 8'd1;
        end else if (fcnt_q == '0) begin
          state_d = ST_RUN;
        end else begin
          fcnt_d = fcnt_q - 1'b1;
        end
      end
      default: state_d = ST_POR;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_POR;
      fcnt_q  <= POR_LOAD;
      pulse_q <= 1'b0;
      count_q <= 8'd0;
      soc_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pulse_q <= pulse_d;
      count_q <= count_d;
      soc_q   <= (state_d != ST_RUN);
    end
  end

  assign soc_reset   = soc_q;
  assign press_pulse = pulse_q;
  assign press_count = count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_gpio_reset_conditioner.sv
// Bench for gpio_reset_conditioner: a vector table plus hand-written sequences,
// with expected values queued at drive time and checked on the falling edge.
module tb_gpio_reset_conditioner;

  localparam int S_DB    = 0;
  localparam int S_SOC   = 1;
  localparam int S_PULSE = 2;
  localparam int S_CNT   = 3;
  localparam int S_STATE = 4;

  logic       clock;
  logic       reset;
  logic [3:0] gpio_in;
  logic [3:0] gpio_db, gpio_db_s;
  logic       soc_reset, soc_reset_s;
  logic       press_pulse, press_pulse_s;
  logic [7:0] press_count, press_count_s;
  logic [1:0] state_dbg, state_dbg_s;

  gpio_reset_conditioner dut (
    .clock       (clock),
    .reset       (reset),
    .gpio_in     (gpio_in),
    .gpio_db     (gpio_db),
    .soc_reset   (soc_reset),
    .press_pulse (press_pulse),
    .press_count (press_count),
    .state_dbg   (state_dbg)
  );

  // Long-stretch instance so a debounced re-press can land inside STRETCH.
  gpio_reset_conditioner #(.RST_STRETCH(128)) dut_s (
    .clock       (clock),
    .reset       (reset),
    .gpio_in     (gpio_in),
    .gpio_db     (gpio_db_s),
    .soc_reset   (soc_reset_s),
    .press_pulse (press_pulse_s),
    .press_count (press_count_s),
    .state_dbg   (state_dbg_s)
  );

  typedef struct {
    int    at;
    int    d;
    int    sig;
    int    idx;
    int    val;
    string name;
  } chk_t;

  typedef struct {
    string name;
    int    bit_idx;
    logic  lvl;
    int    hold;
    logic  chg;
    logic  rst;
    int    cnt;
  } vec_t;

  chk_t sb[$];
  vec_t vecs[7];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic int actual(int d, int sig, int idx);
    logic [3:0] db;
    logic       soc, pl;
    logic [7:0] pc;
    logic [1:0] st;
    if (d == 0) begin
      db = gpio_db;   soc = soc_reset;   pl = press_pulse;   pc = press_count;   st = state_dbg;
    end else begin
      db = gpio_db_s; soc = soc_reset_s; pl = press_pulse_s; pc = press_count_s; st = state_dbg_s;
    end
    case (sig)
      S_DB:    return int'(db[idx]);
      S_SOC:   return int'(soc);
      S_PULSE: return int'(pl);
      S_CNT:   return int'(pc);
      S_STATE: return int'(st);
      default: return -1;
    endcase
  endfunction

  int act_v;
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        act_v = actual(sb[i].d, sb[i].sig, sb[i].idx);
        total++;
        if (act_v != sb[i].val) begin
          bad++;
          $display("FAIL %s dut=%0d cyc=%0d got=%0d want=%0d",
                   sb[i].name, sb[i].d, cyc, act_v, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int at, input int d, input int sig, input int idx,
                           input int val, input string name);
    chk_t c;
    c.at = at; c.d = d; c.sig = sig; c.idx = idx; c.val = val; c.name = name;
    sb.push_back(c);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && sb.size() != 0; i++) tick(1);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d first=%s", sb.size(), sb[0].name);
      sb.delete();
    end
  endtask

  task automatic por_checks(input int r);
    for (int d = 0; d < 2; d++) begin
      expect_at(r + 1,  d, S_SOC,   0, 1, "por_soc_start");
      expect_at(r + 31, d, S_SOC,   0, 1, "por_soc_last");
      expect_at(r + 31, d, S_STATE, 0, 0, "por_state_last");
      expect_at(r + 32, d, S_SOC,   0, 0, "por_soc_off");
      expect_at(r + 32, d, S_STATE, 0, 1, "por_state_run");
      expect_at(r + 32, d, S_CNT,   0, 0, "por_count");
      expect_at(r + 32, d, S_DB,    0, 1, "por_db0");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(5);
    chk("rst_soc",   int'(soc_reset),   1);
    chk("rst_pulse", int'(press_pulse), 0);
    chk("rst_count", int'(press_count), 0);
    chk("rst_state", int'(state_dbg),   0);
    chk("rst_db",    int'(gpio_db),     1);
    reset = 1'b0;
    $display("reset released at cyc=%0d", cyc);
    por_checks(cyc);
    tick(40);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  vec_t       v;
  int         t, r, a;
  logic [3:0] idle_v;

  initial begin
    vecs[0] = '{"press_clean",   0, 1'b0, 100, 1'b1, 1'b1, 1};
    vecs[1] = '{"press_min64",   0, 1'b0,  64, 1'b1, 1'b1, 2};
    vecs[2] = '{"press_short63", 0, 1'b0,  63, 1'b0, 1'b0, 2};
    vecs[3] = '{"gpio3_a",       3, 1'b1, 100, 1'b1, 1'b0, 2};
    vecs[4] = '{"gpio3_b",       3, 1'b1, 100, 1'b1, 1'b0, 2};
    vecs[5] = '{"gpio2_min64",   2, 1'b1,  64, 1'b1, 1'b0, 2};
    vecs[6] = '{"gpio1_short63", 1, 1'b1,  63, 1'b0, 1'b0, 2};
    idle_v  = 4'b0001;
    reset   = 1'b1;
    gpio_in = 4'b0001;

    do_reset();

    // Glitch rejection: 30 low, then 5-cycle bounce for 200 cycles, ending high.
    t = cyc;
    for (int j = 0; j <= 30; j++) begin
      expect_at(t + 10 * j, 0, S_DB,  0, 1, "glitch_db0");
      expect_at(t + 10 * j, 0, S_SOC, 0, 0, "glitch_soc");
    end
    expect_at(t + 300, 0, S_CNT, 0, 0, "glitch_count");
    $display("glitch sequence start cyc=%0d", t);
    gpio_in[0] = 1'b0;
    tick(30);
    for (int k = 0; k < 40; k++) begin
      gpio_in[0] = (k % 2 == 0);
      tick(5);
    end
    gpio_in[0] = 1'b1;
    drain();

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      t = cyc;
      a = v.chg ? int'(v.lvl) : int'(idle_v[v.bit_idx]);
      gpio_in[v.bit_idx] = v.lvl;
      expect_at(t + 65,          0, S_DB,    v.bit_idx, int'(idle_v[v.bit_idx]), {v.name, "_db_pre"});
      expect_at(t + 66,          0, S_DB,    v.bit_idx, a,                        {v.name, "_db_edge"});
      expect_at(t + v.hold + 65, 0, S_DB,    v.bit_idx, a,                        {v.name, "_db_hold"});
      expect_at(t + v.hold + 66, 0, S_DB,    v.bit_idx, int'(idle_v[v.bit_idx]), {v.name, "_db_back"});
      expect_at(t + 66,          0, S_SOC,   0, 0,          {v.name, "_soc_pre"});
      expect_at(t + 67,          0, S_SOC,   0, int'(v.rst), {v.name, "_soc_rise"});
      expect_at(t + 67,          0, S_PULSE, 0, int'(v.rst), {v.name, "_pulse"});
      expect_at(t + 68,          0, S_PULSE, 0, 0,          {v.name, "_pulse_end"});
      expect_at(t + v.hold + 82, 0, S_SOC,   0, int'(v.rst), {v.name, "_soc_stretch"});
      expect_at(t + v.hold + 83, 0, S_SOC,   0, 0,          {v.name, "_soc_fall"});
      expect_at(t + v.hold + 83, 0, S_STATE, 0, 1,          {v.name, "_state_run"});
      expect_at(t + v.hold + 90, 0, S_CNT,   0, v.cnt,      {v.name, "_count"});
      $display("vec %s bit=%0d lvl=%0d hold=%0d cyc=%0d", v.name, v.bit_idx, v.lvl, v.hold, t);
      tick(v.hold);
      gpio_in[v.bit_idx] = idle_v[v.bit_idx];
      tick(120);
    end
    drain();

    // Re-press 8 cycles into STRETCH; short-stretch unit briefly runs, long one never does.
    do_reset();
    t = cyc;
    $display("re-press sequence start cyc=%0d", t);
    for (int d = 0; d < 2; d++) begin
      expect_at(t + 67,  d, S_SOC,   0, 1, "rp_soc_first");
      expect_at(t + 67,  d, S_PULSE, 0, 1, "rp_pulse_first");
      expect_at(t + 167, d, S_STATE, 0, 3, "rp_enter_stretch");
      expect_at(t + 242, d, S_PULSE, 0, 1, "rp_pulse_second");
      expect_at(t + 242, d, S_STATE, 0, 2, "rp_held_again");
      expect_at(t + 242, d, S_SOC,   0, 1, "rp_soc_second");
      expect_at(t + 480, d, S_CNT,   0, 2, "rp_count");
    end
    expect_at(t + 182, 0, S_SOC,   0, 1, "rp_short_soc_182");
    expect_at(t + 183, 0, S_SOC,   0, 0, "rp_short_soc_183");
    expect_at(t + 200, 0, S_STATE, 0, 1, "rp_short_run");
    expect_at(t + 241, 0, S_SOC,   0, 0, "rp_short_soc_241");
    expect_at(t + 357, 0, S_SOC,   0, 1, "rp_short_soc_357");
    expect_at(t + 358, 0, S_SOC,   0, 0, "rp_short_soc_358");
    expect_at(t + 183, 1, S_SOC,   0, 1, "rp_long_soc_183");
    expect_at(t + 200, 1, S_SOC,   0, 1, "rp_long_soc_200");
    expect_at(t + 241, 1, S_SOC,   0, 1, "rp_long_soc_241");
    expect_at(t + 241, 1, S_STATE, 0, 3, "rp_long_stretch_241");
    expect_at(t + 469, 1, S_SOC,   0, 1, "rp_long_soc_469");
    expect_at(t + 470, 1, S_SOC,   0, 0, "rp_long_soc_470");
    gpio_in[0] = 1'b0;
    tick(100);
    gpio_in[0] = 1'b1;
    tick(75);
    gpio_in[0] = 1'b0;
    tick(100);
    gpio_in[0] = 1'b1;
    tick(220);
    drain();

    // Saturation: 260 minimum-length presses.
    do_reset();
    for (int k = 1; k <= 260; k++) begin
      t = cyc;
      expect_at(t + 66, 0, S_PULSE, 0, 0, "sat_pulse_pre");
      expect_at(t + 67, 0, S_PULSE, 0, 1, "sat_pulse");
      expect_at(t + 68, 0, S_CNT,   0, (k > 255) ? 255 : k, "sat_count");
      $display("press %0d cyc=%0d", k, t);
      gpio_in[0] = 1'b0;
      tick(64);
      gpio_in[0] = 1'b1;
      tick(86);
    end
    drain();

    // Asynchronous reset while HELD, button kept down through and after reset.
    t = cyc;
    $display("async reset sequence start cyc=%0d", t);
    expect_at(t + 67, 0, S_SOC,   0, 1, "ar_soc_held");
    expect_at(t + 68, 0, S_STATE, 0, 2, "ar_state_held");
    gpio_in[0] = 1'b0;
    tick(80);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_soc_now",   int'(soc_reset),   1);
    chk("ar_state_now", int'(state_dbg),   0);
    chk("ar_count_now", int'(press_count), 0);
    chk("ar_db_now",    int'(gpio_db),     1);
    tick(3);
    reset = 1'b0;
    r = cyc;
    expect_at(r + 31, 0, S_SOC,   0, 1, "ar_por_soc_last");
    expect_at(r + 32, 0, S_SOC,   0, 0, "ar_por_soc_off");
    expect_at(r + 32, 0, S_STATE, 0, 1, "ar_por_run");
    expect_at(r + 65, 0, S_DB,    0, 1, "ar_db_pre");
    expect_at(r + 66, 0, S_DB,    0, 0, "ar_db_fall");
    expect_at(r + 66, 0, S_PULSE, 0, 0, "ar_pulse_pre");
    expect_at(r + 67, 0, S_PULSE, 0, 1, "ar_pulse");
    expect_at(r + 67, 0, S_SOC,   0, 1, "ar_soc_rise");
    expect_at(r + 68, 0, S_CNT,   0, 1, "ar_count");
    tick(100);
    gpio_in[0] = 1'b1;
    tick(200);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
